// File: rtl/spi_image_master.sv
// SPI mode-0 master that plays the external host for the recognizer's SPI slave.
// Per image it sends a start byte (0x00), NUM_PIX_BYTES pixel bytes pulled from a
// ready/valid stream, and an end byte (0xFF). It then idles RESULT_WAIT cycles and
// clocks one result byte back from MISO. Bytes travel LSB first in both directions.
module spi_image_master #(
    parameter int HALF_PERIOD   = 8,     // clk cycles per SCK half-period, >= 2
    parameter int NUM_PIX_BYTES = 72,    // pixel bytes per frame
    parameter int RESULT_WAIT   = 6000,  // idle cycles between the end byte and the result read
    parameter int GAP_CYCLES    = 16     // SS-high cycles after every byte
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic       SCK,
    output logic       SS,
    output logic       MOSI,
    input  logic       MISO,
    output logic       busy,
    output logic [7:0] result,
    output logic       result_valid
);

    localparam int HW       = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
    localparam int IDLE_MAX = (RESULT_WAIT > GAP_CYCLES) ? RESULT_WAIT : GAP_CYCLES;
    localparam int IW       = $clog2(IDLE_MAX + 1);
    localparam int PW       = $clog2(NUM_PIX_BYTES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_SOF,
        ST_FETCH,
        ST_SEND_PIX,
        ST_SEND_EOF,
        ST_WAIT,
        ST_READ,
        ST_DONE
    } state_t;

    state_t        state;
    logic [HW-1:0] half_cnt;   // position inside the current SCK half-period
    logic [2:0]    bit_cnt;    // bit being shifted; wraps back to 0 after bit 7
    logic          in_gap;     // byte bits finished, SS high, counting the gap
    logic [IW-1:0] idle_cnt;   // shared by the inter-byte gap and the result wait
    logic [PW-1:0] pix_cnt;    // pixel bytes already sent in this frame
    logic [7:0]    tx_shift;   // tx_shift[0] is the bit currently on MOSI
    logic [7:0]    rx_shift;

    logic byte_state;
    logic half_done;
    logic gap_done;
    logic byte_end;

    assign byte_state = (state == ST_SEND_SOF) || (state == ST_SEND_PIX) ||
                        (state == ST_SEND_EOF) || (state == ST_READ);
    assign half_done  = (half_cnt == HW'(HALF_PERIOD - 1));
    assign gap_done   = in_gap && (idle_cnt == IW'(GAP_CYCLES - 1));
    // Last gap cycle of the current byte: the sequencer moves on at this edge,
    // and may start the next byte in the same edge.
    assign byte_end   = byte_state && gap_done;

    // Frame sequencer and byte engine; every output is a register.
    // NOTE: sequential state uses non-blocking assignments only, so each register
    // sees pre-edge values of all others regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            SCK          <= 1'b0;
            SS           <= 1'b1;
            MOSI         <= 1'b1;
            pix_ready    <= 1'b0;
            busy         <= 1'b0;
            result       <= 8'h00;
            result_valid <= 1'b0;
            half_cnt     <= '0;
            bit_cnt      <= '0;
            in_gap       <= 1'b0;
            idle_cnt     <= '0;
            pix_cnt      <= '0;
            tx_shift     <= 8'h00;
            rx_shift     <= 8'h00;
        end else begin
            result_valid <= 1'b0;

            // Byte engine. Loading a byte (SS low, MOSI = bit 0) is done by the
            // sequencer below; the counters are already back at 0 by then.
            if (byte_state) begin
                if (!in_gap) begin
                    if (half_done) begin
                        half_cnt <= '0;
                        if (!SCK) begin
                            SCK <= 1'b1;
                            // MISO is not synchronized: the slave runs on this same clk.
                            if (state == ST_READ) begin
                                rx_shift <= {MISO, rx_shift[7:1]};
                            end
                        end else begin
                            SCK     <= 1'b0;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                SS     <= 1'b1;
                                MOSI   <= 1'b1;
                                in_gap <= 1'b1;
                            end else begin
                                MOSI     <= tx_shift[1];
                                tx_shift <= {1'b1, tx_shift[7:1]};
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end else if (gap_done) begin
                    in_gap   <= 1'b0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end

            // Frame sequencer
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        pix_cnt  <= '0;
                        SS       <= 1'b0;
                        MOSI     <= 1'b0;
                        tx_shift <= 8'h00;
                        state    <= ST_SEND_SOF;
                    end
                end
                ST_SEND_SOF: begin
                    if (byte_end) begin
                        pix_ready <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // A stall here simply holds SS high and SCK low.
                    if (pix_valid && pix_ready) begin
                        pix_ready <= 1'b0;
                        SS        <= 1'b0;
                        MOSI      <= pix_data[0];
                        tx_shift  <= pix_data;
                        state     <= ST_SEND_PIX;
                    end
                end
                ST_SEND_PIX: begin
                    if (byte_end) begin
                        pix_cnt <= pix_cnt + PW'(1);
                        if (pix_cnt == PW'(NUM_PIX_BYTES - 1)) begin
                            SS       <= 1'b0;
                            MOSI     <= 1'b1;
                            tx_shift <= 8'hFF;
                            state    <= ST_SEND_EOF;
                        end else begin
                            pix_ready <= 1'b1;
                            state     <= ST_FETCH;
                        end
                    end
                end
                ST_SEND_EOF: begin
                    if (byte_end) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (idle_cnt == IW'(RESULT_WAIT - 1)) begin
                        idle_cnt <= '0;
                        SS       <= 1'b0;
                        MOSI     <= 1'b1;
                        tx_shift <= 8'hFF;
                        state    <= ST_READ;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                ST_READ: begin
                    if (byte_end) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    result       <= rx_shift;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_image_master.sv
// Self-checking bench for spi_image_master. A monitor decodes every SPI byte off
// the wire and pops the expected byte stream and the expected results. It also
// checks the mode-0 timing and acts as the slave that returns the result byte.
// The driver feeds the frames and queues up what each one should produce.
module tb_spi_image_master;

    localparam int HP   = 8;
    localparam int NPIX = 72;
    localparam int RW   = 300;
    localparam int GAP  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       SCK;
    logic       SS;
    logic       MOSI;
    logic       MISO;
    logic       busy;
    logic [7:0] result;
    logic       result_valid;

    always #5 clk = ~clk;

    spi_image_master #(
        .HALF_PERIOD  (HP),
        .NUM_PIX_BYTES(NPIX),
        .RESULT_WAIT  (RW),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .SCK         (SCK),
        .SS          (SS),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];      // bytes expected on MOSI, in wire order
    logic [7:0] exp_res_q[$];  // results expected on result_valid
    logic [7:0] slave_byte = 8'h00;
    int         rv_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / slave: samples on the falling clk edge, away from DUT updates.
    int         rises, ss_low_cnt, ss_high_cnt, mosi_stable;
    logic       prev_sck, prev_ss, prev_mosi, prev_rv, idle_bad;
    logic [7:0] mbyte, e;

    initial begin
        MISO = 1'b1;
        rises = 0; ss_low_cnt = 0; ss_high_cnt = 1000; mosi_stable = 100;
        prev_sck = 1'b0; prev_ss = 1'b1; prev_mosi = 1'b1; prev_rv = 1'b0;
        idle_bad = 1'b0; mbyte = 8'h00;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                rises = 0; ss_low_cnt = 0; ss_high_cnt = 1000; mosi_stable = 100;
                prev_sck = 1'b0; prev_ss = 1'b1; prev_mosi = 1'b1; prev_rv = 1'b0;
                idle_bad = 1'b0; MISO = 1'b1;
            end else begin
                if (MOSI !== prev_mosi) mosi_stable = 0;
                else if (mosi_stable < 1000) mosi_stable++;

                if (prev_ss && !SS) begin
                    check("gap_before_byte", 32'(ss_high_cnt >= GAP), 1);
                    check("idle_sck_low_mosi_high", idle_bad, 0);
                    rises = 0;
                    ss_low_cnt = 1;
                    mbyte = 8'h00;
                end else if (!SS) begin
                    ss_low_cnt++;
                end

                if (!SS && SCK && !prev_sck) begin
                    check("mosi_setup_before_rise", 32'(mosi_stable >= HP), 1);
                    if (rises < 8) mbyte[rises[2:0]] = MOSI;
                    rises++;
                end

                if (!prev_ss && SS) begin
                    check("sck_rises_per_byte", rises, 8);
                    check("ss_low_cycles", ss_low_cnt, 16 * HP);
                    check("busy_during_frame", busy, 1);
                    if (exp_q.size() == 0) begin
                        check("byte_unexpected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("mosi_byte", mbyte, e);
                    end
                    ss_high_cnt = 1;
                    idle_bad = 1'b0;
                end else if (SS) begin
                    ss_high_cnt++;
                    if (SCK !== 1'b0 || MOSI !== 1'b1) idle_bad = 1'b1;
                end

                if (prev_rv) check("result_valid_single", result_valid, 0);
                if (result_valid === 1'b1) begin
                    rv_cnt++;
                    if (exp_res_q.size() == 0) begin
                        check("result_unexpected", exp_res_q.size(), 1);
                    end else begin
                        e = exp_res_q.pop_front();
                        check("result", result, e);
                    end
                end

                // Slave side: present the next result bit while SCK is low.
                if (!SS && !SCK && rises < 8) MISO = slave_byte[rises[2:0]];
                else if (SS) MISO = 1'b1;

                prev_sck  = SCK;
                prev_ss   = SS;
                prev_mosi = MOSI;
                prev_rv   = result_valid;
            end
        end
    end

    // Wait (bounded) until the DUT offers pix_ready; called on a falling edge.
    task automatic wait_ready(output bit ok);
        int n = 0;
        while (pix_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("pix_ready_seen", pix_ready, 1);
        ok = (pix_ready === 1'b1);
    endtask

    // One frame. const_pix: all pixels 0x21. stall_at / spur_at / rst_at are pixel
    // indices (-1 = unused) for a 200-cycle valid drop, an ignored start pulse and
    // a reset mid-bit of that pixel byte.
    task automatic run_frame(input bit const_pix, input int stall_at, input int spur_at,
                             input int rst_at, input logic [7:0] res, input bit hold_check);
        logic [7:0] pix[NPIX];
        bit ok;
        bit stall_bad;
        int n;
        for (int k = 0; k < NPIX; k++) pix[k] = const_pix ? 8'h21 : 8'($urandom);
        exp_q.push_back(8'h00);
        for (int k = 0; k < NPIX; k++) exp_q.push_back(pix[k]);
        exp_q.push_back(8'hFF);   // end-of-frame byte
        exp_q.push_back(8'hFF);   // MOSI held high during the result read
        exp_res_q.push_back(res);
        slave_byte = res;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        pix_valid = 1'b1;

        for (int i = 0; i < NPIX; i++) begin
            if (i == stall_at) begin
                pix_valid = 1'b0;
                wait_ready(ok);
                if (!ok) return;
                stall_bad = 1'b0;
                repeat (200) begin
                    @(negedge clk);
                    if (SS !== 1'b1 || SCK !== 1'b0 || pix_ready !== 1'b1) stall_bad = 1'b1;
                end
                check("stall_bus_idle", stall_bad, 0);
                pix_valid = 1'b1;
            end
            pix_data = pix[i];
            wait_ready(ok);
            if (!ok) return;
            @(negedge clk);   // handshake happened on the rising edge just passed
            if (i == spur_at) begin
                repeat (40) @(negedge clk);
                check("busy_mid_frame", busy, 1);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if (i == rst_at) begin
                repeat (3 * HP + 3) @(negedge clk);
                check("ss_low_before_reset", SS, 0);
                #2;
                rst = 1'b1;
                #1;
                check("rst_ss", SS, 1);
                check("rst_sck", SCK, 0);
                check("rst_mosi", MOSI, 1);
                check("rst_busy", busy, 0);
                check("rst_pix_ready", pix_ready, 0);
                pix_valid = 1'b0;
                exp_q.delete();
                exp_res_q.delete();
                repeat (3) @(negedge clk);
                rst = 1'b0;
                repeat (20) @(negedge clk);
                return;
            end
        end
        pix_valid = 1'b0;

        n = 0;
        while (result_valid !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("result_valid_seen", result_valid, 1);
        check("busy_low_at_result", busy, 0);
        if (hold_check) begin
            repeat (5) @(negedge clk);
            check("result_holds", result, res);
            check("busy_stays_low", busy, 0);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_sck", SCK, 0);
        check("reset_ss", SS, 1);
        check("reset_mosi", MOSI, 1);
        check("reset_pix_ready", pix_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_result", result, 8'h00);
        check("reset_result_valid", result_valid, 0);
        repeat (20) @(negedge clk);

        // Random pixels, stall before pixel 10, ignored start at pixel 30, result 0x07.
        run_frame(1'b0, 10, 30, -1, 8'h07, 1'b0);
        // Back-to-back: start one cycle after result_valid, constant 0x21 pixels.
        run_frame(1'b1, -1, -1, -1, 8'($urandom), 1'b1);
        repeat (20) @(negedge clk);
        // Reset mid-bit of pixel byte 5, then a full random frame.
        run_frame(1'b0, -1, -1, 5, 8'($urandom), 1'b0);
        run_frame(1'b0, -1, -1, -1, 8'($urandom), 1'b1);
        repeat (50) @(negedge clk);

        check("all_bytes_seen", exp_q.size(), 0);
        check("all_results_seen", exp_res_q.size(), 0);
        check("result_valid_count", rv_cnt, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
